// File: rtl/exp_golomb_parser_pkg.sv
// Shared types and width derivations for the order-0 Exp-Golomb parser.
package exp_golomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Number of bits needed to hold x itself (so a pop of up to WIDTH fits).
  function automatic int log2(input int x);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= x) n = i + 1;
    end
    return n;
  endfunction

  function automatic int max_prefix(input int width);
    return (width - 1) / 2;
  endfunction

  function automatic int value_width(input int width);
    return max_prefix(width) + 1;
  endfunction

  localparam int EG_WIDTH       = 64;
  localparam int EG_COUNT_WIDTH = 16;

endpackage

// File: rtl/exp_golomb_parser_if.sv
// Command, upstream-window and value-FIFO signals of the Exp-Golomb parser.
interface exp_golomb_parser_if #(
  parameter int WIDTH       = exp_golomb_pkg::EG_WIDTH,
  parameter int LOG2_WIDTH  = exp_golomb_pkg::log2(WIDTH),
  parameter int VALUE_WIDTH = exp_golomb_pkg::value_width(WIDTH),
  parameter int COUNT_WIDTH = exp_golomb_pkg::EG_COUNT_WIDTH
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] count;
  logic [WIDTH-1:0]       q;
  logic                   ready;
  logic [LOG2_WIDTH-1:0]  pop;
  logic [VALUE_WIDTH-1:0] value;
  logic                   value_push;
  logic                   value_full;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output start, count, q, ready, value_full,
    input  pop, value, value_push, busy, done, error
  );

  modport slave (
    input  start, count, q, ready, value_full,
    output pop, value, value_push, busy, done, error
  );
endinterface

// File: rtl/exp_golomb_parser_trailing_zero_count.sv
// Priority encoder: index of the lowest set bit, i.e. the Exp-Golomb zero prefix length.
module trailing_zero_count #(
  parameter int MAX_PREFIX = 31,
  parameter int LOG2_WIDTH = 7
) (
  input  logic [MAX_PREFIX:0]   bits,
  output logic [LOG2_WIDTH-1:0] n,
  output logic                  found
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    n     = '0;
    found = 1'b0;
    for (int i = MAX_PREFIX; i >= 0; i--) begin
      if (bits[i]) begin
        n     = LOG2_WIDTH'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp_golomb_parser.sv
// Command-driven order-0 Exp-Golomb parser reading an LSB-first upstream bit window.
module exp_golomb_parser
  import exp_golomb_pkg::*;
#(
  parameter int WIDTH       = EG_WIDTH,
  parameter int LOG2_WIDTH  = log2(WIDTH),
  parameter int MAX_PREFIX  = max_prefix(WIDTH),
  parameter int VALUE_WIDTH = value_width(WIDTH),
  parameter int COUNT_WIDTH = EG_COUNT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  exp_golomb_parser_if.slave bus
);

  state_t                 state;
  state_t                 next_state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [LOG2_WIDTH-1:0]  zero_count;
  logic                   found;
  logic                   fire;
  logic                   malformed;
  logic [WIDTH-1:0]       shifted;
  logic [VALUE_WIDTH-1:0] leading;
  logic [VALUE_WIDTH-1:0] decoded;

  trailing_zero_count #(
    .MAX_PREFIX(MAX_PREFIX),
    .LOG2_WIDTH(LOG2_WIDTH)
  ) u_tzc (
    .bits (bus.q[MAX_PREFIX:0]),
    .n    (zero_count),
    .found(found)
  );

  assign fire      = (state == ST_RUN) && bus.ready && !bus.value_full && found;
  assign malformed = (state == ST_RUN) && bus.ready && !found;

  // The terminator is the implicit leading one; the suffix sits just above it.
  assign shifted = bus.q >> (zero_count + LOG2_WIDTH'(1));
  assign leading = VALUE_WIDTH'(1) << zero_count;
  assign decoded = (leading | (shifted[VALUE_WIDTH-1:0] & (leading - VALUE_WIDTH'(1))))
                   - VALUE_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.start) next_state = (bus.count != '0) ? ST_RUN : ST_DONE;
      ST_RUN: begin
        if (malformed)                                       next_state = ST_ERR;
        else if (fire && (remaining == COUNT_WIDTH'(1)))     next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      ST_ERR:  next_state = ST_ERR;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.pop   = '0;
    if (fire) bus.pop = (zero_count << 1) | LOG2_WIDTH'(1);
    bus.busy  = (state != ST_IDLE);
    bus.done  = (state == ST_DONE);
    bus.error = (state == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             remaining <= '0;
    else if (state == ST_IDLE && bus.start) remaining <= bus.count;
    else if (fire)                        remaining <= remaining - COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.value      <= '0;
      bus.value_push <= 1'b0;
    end else begin
      bus.value_push <= fire;
      if (fire) bus.value <= decoded;
    end
  end

endmodule

// File: tb/tb_exp_golomb_parser.sv
// Randomized bench for exp_golomb_parser: codes are built by an encoder model and decoded back.
module tb_exp_golomb_parser;

  localparam int CMD_BUDGET = 400;

  logic clk = 1'b0;
  logic rst;

  exp_golomb_parser_if bus ();

  exp_golomb_parser dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] codes[$];

  function automatic int msb_index(input logic [32:0] c);
    int n;
    n = 0;
    for (int i = 0; i < 33; i++) if (c[i]) n = i;
    return n;
  endfunction

  // Code for v: N zeros, a one, then the N low bits of v+1 (LSB first), junk above.
  function automatic logic [63:0] encode(input logic [31:0] v, input logic [63:0] junk);
    logic [32:0] c;
    logic [63:0] w;
    int n;
    c = 33'(v) + 33'd1;
    n = msb_index(c);
    w = junk;
    for (int i = 0; i <= 2 * n; i++) begin
      if (i < n)       w[i] = 1'b0;
      else if (i == n) w[i] = 1'b1;
      else             w[i] = c[i - n - 1];
    end
    return w;
  endfunction

  function automatic logic [6:0] code_len(input logic [31:0] v);
    return 7'(2 * msb_index(33'(v) + 33'd1) + 1);
  endfunction

  function automatic logic [31:0] rand_value();
    int n;
    logic [32:0] c;
    n = $urandom_range(31, 0);
    c = (33'd1 << n) | (33'($urandom) & ((33'd1 << n) - 33'd1));
    return 32'(c - 33'd1);
  endfunction

  task automatic run_command(input int ready_pct, input int full_pct, input int stall_at,
                             input int stall_len, input bit inject_start);
    int n_codes;
    int sent;
    int cyc;
    logic rdy;
    logic full;
    logic [6:0] exp_pop;
    logic fired;
    n_codes = codes.size();
    bus.start = 1'b1;
    bus.count = 16'(n_codes);
    bus.ready = 1'b0;
    bus.value_full = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_after_start: got %b expected 1", bus.busy);
    end
    sent = 0;
    cyc = 0;
    while (sent < n_codes && cyc < CMD_BUDGET) begin
      rdy  = ($urandom_range(99, 0) < ready_pct);
      full = ($urandom_range(99, 0) < full_pct) || (cyc >= stall_at && cyc < stall_at + stall_len);
      bus.start = inject_start && (cyc == 1);
      bus.count = 16'($urandom_range(65535, 1));
      bus.ready = rdy;
      bus.value_full = full;
      bus.q = encode(codes[sent], {$urandom, $urandom});
      #1;
      fired = rdy && !full;
      exp_pop = fired ? code_len(codes[sent]) : 7'd0;
      vectors++;
      if (bus.pop !== exp_pop) begin
        miscompares++;
        $display("[TB] FAIL pop: got %0d expected %0d (code %0d)", bus.pop, exp_pop, sent);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.value_push !== fired) begin
        miscompares++;
        $display("[TB] FAIL value_push: got %b expected %b", bus.value_push, fired);
      end
      if (fired) begin
        vectors++;
        if (bus.value !== codes[sent]) begin
          miscompares++;
          $display("[TB] FAIL value: got %h expected %h", bus.value, codes[sent]);
        end
        sent++;
      end
      vectors++;
      if (bus.done !== (fired && sent == n_codes)) begin
        miscompares++;
        $display("[TB] FAIL done: got %b expected %b", bus.done, fired && sent == n_codes);
      end
      cyc++;
    end
    bus.start = 1'b0;
    bus.ready = 1'b0;
    vectors++;
    if (sent != n_codes) begin
      miscompares++;
      $display("[TB] FAIL timeout: decoded %0d expected %0d", sent, n_codes);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.value_push !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL back_to_idle: busy %b done %b push %b expected 0 0 0",
               bus.busy, bus.done, bus.value_push);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    bus.q = {$urandom, $urandom};
    bus.ready = 1'b1;
    bus.value_full = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.pop, bus.value, bus.value_push, bus.busy, bus.done, bus.error} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: pop %0d value %h push %b busy %b done %b error %b expected all 0",
               bus.pop, bus.value, bus.value_push, bus.busy, bus.done, bus.error);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.ready = 1'b0;
  endtask

  task automatic test_decode_sequence();
    codes = '{32'd0, 32'd3, 32'd5};
    run_command(100, 0, 0, 0, 1'b0);
  endtask

  task automatic test_max_code();
    codes = '{32'hFFFF_FFFE};
    run_command(100, 0, 0, 0, 1'b0);
  endtask

  task automatic test_full_stall();
    codes.delete();
    for (int i = 0; i < 8; i++) codes.push_back(rand_value());
    run_command(100, 0, 3, 4, 1'b0);
  endtask

  task automatic test_random_commands();
    for (int k = 0; k < 6; k++) begin
      codes.delete();
      for (int i = 0; i < $urandom_range(12, 1); i++) codes.push_back(rand_value());
      run_command(70, 25, 0, 0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    bus.count = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.done !== 1'b1 || bus.value_push !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL count_zero: done %b push %b busy %b expected 1 0 1",
               bus.done, bus.value_push, bus.busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL count_zero_idle: done %b busy %b expected 0 0", bus.done, bus.busy);
    end
    codes.delete();
    for (int i = 0; i < 5; i++) codes.push_back(rand_value());
    run_command(100, 0, 0, 0, 1'b1);
    codes = '{32'd7, 32'd1};
    run_command(100, 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v;
    bus.start = 1'b1;
    bus.count = 16'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v = rand_value();
      bus.ready = 1'b1;
      bus.value_full = 1'b0;
      bus.q = encode(v, {$urandom, $urandom});
      #1;
      vectors++;
      if (bus.pop !== code_len(v)) begin
        miscompares++;
        $display("[TB] FAIL pop_before_reset: got %0d expected %0d", bus.pop, code_len(v));
      end
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.pop, bus.value, bus.value_push, bus.busy, bus.done, bus.error} !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_run_reset: pop %0d value %h push %b busy %b done %b error %b expected all 0",
               bus.pop, bus.value, bus.value_push, bus.busy, bus.done, bus.error);
    end
    bus.ready = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    codes.delete();
    for (int i = 0; i < 4; i++) codes.push_back(rand_value());
    run_command(100, 0, 0, 0, 1'b0);
  endtask

  task automatic test_error();
    bus.start = 1'b1;
    bus.count = 16'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.ready = 1'b1;
    bus.value_full = 1'b1;
    bus.q = {$urandom, 32'h0};
    #1;
    vectors++;
    if (bus.pop !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL pop_on_malformed: got %0d expected 0", bus.pop);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b1 || bus.value_push !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL enter_error: error %b busy %b push %b expected 1 1 0",
               bus.error, bus.busy, bus.value_push);
    end
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      bus.count = 16'd5;
      bus.value_full = 1'b0;
      bus.q = encode(rand_value(), {$urandom, $urandom});
      #1;
      vectors++;
      if (bus.pop !== 7'd0) begin
        miscompares++;
        $display("[TB] FAIL pop_in_error: got %0d expected 0", bus.pop);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.value_push !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL error_sticky: error %b done %b push %b expected 1 0 0",
                 bus.error, bus.done, bus.value_push);
      end
    end
    bus.start = 1'b0;
    bus.ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL error_cleared: error %b busy %b expected 0 0", bus.error, bus.busy);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    $display("[TB] exp_golomb_parser bench starting");
    test_reset();
    test_decode_sequence();
    test_max_code();
    test_full_stall();
    test_random_commands();
    test_back_to_back();
    test_reset_mid_run();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exp_golomb_parser.md
# exp_golomb_parser

Consumer stage placed directly downstream of `argument_decoder`. It reads that block's bit window `q` and `ready` and parses order-0 Exp-Golomb codes, least-significant bit first. For each code it returns the code length on `pop` and pushes the decoded unsigned value into a downstream value FIFO. It is command driven: one `start` carries a value count, and the block decodes exactly that many codes, then pulses `done`.

## Interface
Parameters:
- WIDTH, 64: width of the upstream window `q`.
- LOG2_WIDTH, 7: width of `pop`; matches the upstream `pop` port.
- MAX_PREFIX, (WIDTH-1)/2 = 31: longest legal zero prefix.
- VALUE_WIDTH, MAX_PREFIX+1 = 32: width of a decoded value.
- COUNT_WIDTH, 16: width of the command count.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- count  in  COUNT_WIDTH  number of codes to decode; sampled with `start`.
- q  in  WIDTH  upstream window; `q[0]` is the oldest bit.
- ready  in  1  upstream window is valid.
- pop  out  LOG2_WIDTH  bits consumed this cycle; 0 means no pop.
- value  out  VALUE_WIDTH  decoded value.
- value_push  out  1  write strobe for `value`.
- value_full  in  1  downstream almost-full; must reserve at least 1 free slot.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- error  out  1  sticky; asserted in ERR.

## Operation
States:
- IDLE -> RUN on `start` with `count` != 0.
- IDLE -> DONE on `start` with `count` == 0.
- RUN -> DONE when the last code is popped.
- RUN -> ERR on a malformed window.
- DONE -> IDLE unconditionally.
- ERR is left only by reset.

Code parsing:
- N = number of consecutive zeros starting at `q[0]`; the terminator is `q[N]` = 1.
- suffix = `q[2N:N+1]`, with `q[N+1]` as the suffix LSB.
- Code length L = 2N+1.
- value = ((1<<N) | suffix) - 1, zero-extended to VALUE_WIDTH. The maximum value is 2^32 - 2.

Fire condition:
- fire = RUN && `ready` && !`value_full` && terminator found (N <= MAX_PREFIX).
- On fire: `pop` = L (combinational), `remaining` decrements, `value` is registered.
- Without fire, `pop` = 0.

Malformed window:
- RUN && `ready` && `q[MAX_PREFIX:0]` == 0 -> ERR, with no pop.
- This check is independent of `value_full`.

Other rules:
- `start` outside IDLE is ignored; `count` is not sampled.
- `pop` is never nonzero when `ready` = 0, in IDLE, DONE or ERR, or in the cycle of the ERR transition.
- Reset (`rst` low, any cycle, including mid-command): state = IDLE, `remaining` = 0, `pop` = 0, `value` = 0, `value_push` = 0, `busy` = 0, `done` = 0, `error` = 0. A partially decoded command is abandoned.

## Timing
- `pop` is combinational from `q`, `ready`, `value_full` and state. It is valid in the fire cycle t.
- Upstream contract: after a pop in cycle t, the window is updated by t+1. `ready` may drop at t+1.
- `value_push` and `value` are registered and appear at t+1, for exactly 1 cycle per fire.
- Throughput is 1 code per cycle while `ready` = 1 and `value_full` = 0.
- Because of the 1-cycle push lag, `value_full` must assert with at least 1 slot free.
- The last fire at t moves the state to DONE at t+1. `done` = 1 at t+1, coincident with the final `value_push`. IDLE follows at t+2.
- `start` with `count` = 0 at t gives `done` at t+1 and no `value_push`.
- `busy` is registered: high from the cycle after an accepted `start` through the DONE cycle.
- `error` is high from the cycle after the ERR transition until reset.

## Structure
- Shared package `exp_golomb_pkg` holds:
  - state encodings IDLE/RUN/DONE/ERR (2 bits);
  - the `log2` function;
  - the MAX_PREFIX and VALUE_WIDTH derivations.
- Sub-module `trailing_zero_count`: a priority encoder over `q[MAX_PREFIX:0]`. Outputs: N (LOG2_WIDTH bits) and `found`.
- The suffix mux, state register, `remaining` counter and output registers live in the top module.

## Test plan
- Reset with `rst` low mid-RUN -> all outputs 0 next cycle. Command abandoned; the next `start` decodes correctly.
- `count` = 3 with windows `q[0]`=1, then `q[4:0]`=5'b00100, then `q[4:0]`=5'b10100, `ready` held high:
  - `pop` = 1, 5, 5 on consecutive cycles;
  - `value_push` with values 0, 3, 5;
  - `done` with the third push.
- Max code `q[30:0]`=0, `q[31]`=1, `q[62:32]` all ones, `count` = 1 -> `pop` = 63, `value` = 32'hFFFFFFFE.
- `value_full` = 1 for 4 cycles mid-command -> `pop` = 0 and no push during the stall; resumes with no lost or duplicated values.
- `q[31:0]` = 0 with `ready` = 1 in RUN -> no pop, `error` = 1 next cycle and stays high; a later `start` is ignored.
- `start` with `count` = 0 -> `done` next cycle and no `value_push`. Also `start` during RUN -> ignored; the original count completes.
